compound_section_sender: RTL and testbench
==========================================

// Module: compound_section_sender
// PURPOSE
//  Parametrised successor of the single-channel compound-type sender.
//  Two-section FSM: offers a CompoundType-style payload (mode, x, y) on a blocking
//  sync/notify output; after each transfer, samples the master input and computes
//  the next payload.
//  Generalised to NUM_CH round-robin output channels, DATA_W-wide x, and a
//  mode-dependent x update; adds a transfer counter.
//  Sits between a master-in data source and NUM_CH blocking consumers.
// PARAMETERS
//  DATA_W   32  width of payload field x
//  NUM_CH   2   number of output channels (>=1); round-robin served
//  STEP     1   increment applied to x in READ mode
//  CNT_W    16  width of xfer_cnt
//  TIMEOUT  16  max wait cycles per offer (used only with CSS_TIMEOUT_EN)
// PORTS
//  clk           in   1             clock, rising edge
//  rst           in   1             asynchronous, active-low reset
//  m_in_mode     in   1             master-in mode: 0=READ, 1=WRITE
//  m_in_x        in   DATA_W        master-in x
//  m_in_y        in   1             master-in y
//  m_in_valid    in   1             master-in sample valid
//  b_out_mode    out  1             offered payload mode (shared by all channels)
//  b_out_x       out  DATA_W        offered payload x
//  b_out_y       out  1             offered payload y
//  b_out_notify  out  NUM_CH        one-hot offer strobe, one bit per channel
//  b_out_sync    in   NUM_CH        per-channel consumer accept
//  xfer_cnt      out  CNT_W         completed transfers, wraps modulo 2^CNT_W
//  timeout_o     out  1             1-cycle pulse on dropped offer
// BEHAVIOUR
//  Reset (rst=0, async), with no pending transfer:
//   - section=SECTION_A; ch_sel=0.
//   - b_out_mode=READ; b_out_x=0; b_out_y=0.
//   - b_out_notify=1 on channel 0 only (offer live straight out of reset).
//   - xfer_cnt=0; timeout_o=0.
//  Reset mid-transfer (any section): aborts the offer; all state returns to reset values.
//  SECTION_A (offer):
//   - notify[ch_sel]=1, other notify bits 0; payload held stable.
//   - Transfer = posedge with notify[ch_sel] & sync[ch_sel].
//   - On transfer: xfer_cnt+1; notify cleared next cycle; go SECTION_B.
//   - sync on non-selected channels is ignored.
//  SECTION_B (compute), notify all 0:
//   - If m_in_valid=0: stay in SECTION_B; sync is ignored.
//   - If m_in_valid=1, at the edge:
//     - m_in_mode=WRITE: x <= m_in_x.
//     - m_in_mode=READ:  x <= x+STEP, truncated to DATA_W (wraps).
//     - y <= m_in_y; mode <= m_in_mode.
//     - ch_sel <= (ch_sel+1) mod NUM_CH.
//     - Go SECTION_A with the new notify bit set the following cycle.
//  Latency and throughput:
//   - Minimum 2 cycles per transfer (A then B), with sync held and m_in_valid=1.
//   - First offer valid in the first cycle after reset release.
//  NUM_CH=1: ch_sel stays 0; behaviour equals the single-channel sender.
//  xfer_cnt wraps from 2^CNT_W-1 to 0 without flag.
// CONFIGURATION
//  CSS_TIMEOUT_EN defined:
//   - A wait counter runs while in SECTION_A; it is cleared on entry to SECTION_A.
//   - After TIMEOUT cycles without sync[ch_sel]: offer dropped, timeout_o pulses 1 cycle.
//   - On drop: go SECTION_B; xfer_cnt unchanged; payload and channel advance as normal.
//   - A sync arriving in the same cycle the timeout expires counts as a transfer, not a drop.
//  CSS_TIMEOUT_EN undefined:
//   - SECTION_A waits indefinitely; timeout_o tied 0; wait counter not instantiated.
// TESTING
//  1 Release rst; sync=0 -> notify=2'b01; payload {READ,0,0} held; xfer_cnt=0.
//  2 Pulse sync[0]; next cycle m_in={WRITE,x=0x55,y=1}, valid=1 ->
//    notify=2'b10, payload {WRITE,0x55,1}, xfer_cnt=1.
//  3 DATA_W=8, x=0xFF, m_in READ, STEP=1 -> x=0x00 after transfer (wrap).
//  4 In SECTION_B hold m_in_valid=0 for 5 cycles with sync=2'b11 ->
//    notify stays 0, xfer_cnt unchanged.
//    Raise valid -> offer resumes on the next channel.
//  5 Assert rst mid-offer on channel 1 -> notify=2'b01, payload {READ,0,0}, xfer_cnt=0.
//  6 CSS_TIMEOUT_EN, TIMEOUT=4, sync=0 -> after 4 cycles timeout_o=1 for one cycle,
//    xfer_cnt=0, channel advances.

Source files
------------

// File: rtl/compound_section_sender.sv
// compound_section_sender
//   Two-section sender. SECTION_A offers a (mode, x, y) payload on one of NUM_CH
//   round-robin blocking channels. SECTION_B waits for a master-in sample and
//   computes the next payload. In READ mode x advances by STEP; in WRITE mode x
//   loads m_in_x. Completed transfers are counted in xfer_cnt, which wraps.
//
// Optional feature: define CSS_TIMEOUT_EN to drop an offer after TIMEOUT cycles
//   without sync. A dropped offer pulses timeout_o for one cycle. Without the macro,
//   the offer waits indefinitely and timeout_o is tied to 0. TIMEOUT must be >= 1.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   m_in_mode     master-in mode (0=READ, 1=WRITE)
//   m_in_x        master-in x (DATA_W)
//   m_in_y        master-in y
//   m_in_valid    master-in sample valid
//   b_out_mode    offered payload mode
//   b_out_x       offered payload x (DATA_W)
//   b_out_y       offered payload y
//   b_out_notify  one-hot offer strobe (NUM_CH)
//   b_out_sync    per-channel consumer accept (NUM_CH)
//   xfer_cnt      completed transfer count (CNT_W, wraps)
//   timeout_o     one-cycle pulse on a dropped offer
module compound_section_sender #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned STEP    = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_in_mode,
  input  logic [DATA_W-1:0] m_in_x,
  input  logic              m_in_y,
  input  logic              m_in_valid,
  output logic              b_out_mode,
  output logic [DATA_W-1:0] b_out_x,
  output logic              b_out_y,
  output logic [NUM_CH-1:0] b_out_notify,
  input  logic [NUM_CH-1:0] b_out_sync,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              timeout_o
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {SectionA, SectionB} section_e;

  section_e          section_q;
  logic [ChW-1:0]    ch_sel_q;
  logic              mode_q;
  logic [DATA_W-1:0] x_q;
  logic              y_q;
  logic [NUM_CH-1:0] notify_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              sync_hit;
  logic [ChW-1:0]    ch_next;
  logic [DATA_W-1:0] x_next;

  // notify_q is one-hot on ch_sel_q while offering, so sync on other channels
  // is masked out here.
  assign sync_hit = |(notify_q & b_out_sync);
  assign ch_next  = (ch_sel_q == ChW'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;
  assign x_next   = m_in_mode ? m_in_x : x_q + DATA_W'(STEP);

`ifdef CSS_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] wait_q;
  logic          timeout_q;
`else
  // TIMEOUT only matters when the timeout feature is built in.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      section_q <= SectionA;
      ch_sel_q  <= '0;
      mode_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= 1'b0;
      notify_q  <= NUM_CH'(1);
      cnt_q     <= '0;
`ifdef CSS_TIMEOUT_EN
      wait_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef CSS_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (section_q)
        SectionA: begin
          // A sync in the expiry cycle wins over the drop.
          if (sync_hit) begin
            cnt_q     <= cnt_q + 1'b1;
            notify_q  <= '0;
            section_q <= SectionB;
          end
`ifdef CSS_TIMEOUT_EN
          else if (wait_q == TW'(TIMEOUT - 1)) begin
            notify_q  <= '0;
            timeout_q <= 1'b1;
            section_q <= SectionB;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        SectionB: begin
          if (m_in_valid) begin
            x_q       <= x_next;
            y_q       <= m_in_y;
            mode_q    <= m_in_mode;
            ch_sel_q  <= ch_next;
            notify_q  <= NUM_CH'(1) << ch_next;
            section_q <= SectionA;
`ifdef CSS_TIMEOUT_EN
            wait_q    <= '0;
`endif
          end
        end
        default: section_q <= SectionA;
      endcase
    end
  end

  assign b_out_mode   = mode_q;
  assign b_out_x      = x_q;
  assign b_out_y      = y_q;
  assign b_out_notify = notify_q;
  assign xfer_cnt     = cnt_q;
`ifdef CSS_TIMEOUT_EN
  assign timeout_o    = timeout_q;
`else
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_compound_section_sender.sv
// Scoreboard bench for compound_section_sender (DATA_W=8, NUM_CH=2, TIMEOUT=4).
// Stimulus pushes the expected offer for each new offer. A negedge monitor pops
// and compares each offer when notify rises from all-zero.
module tb_compound_section_sender;

  localparam int unsigned DW = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst;
  logic          m_in_mode;
  logic [DW-1:0] m_in_x;
  logic          m_in_y;
  logic          m_in_valid;
  logic          b_out_mode;
  logic [DW-1:0] b_out_x;
  logic          b_out_y;
  logic [NC-1:0] b_out_notify;
  logic [NC-1:0] b_out_sync;
  logic [CW-1:0] xfer_cnt;
  logic          timeout_o;

  compound_section_sender #(
    .DATA_W (DW),
    .NUM_CH (NC),
    .STEP   (1),
    .CNT_W  (CW),
    .TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_in_mode   (m_in_mode),
    .m_in_x      (m_in_x),
    .m_in_y      (m_in_y),
    .m_in_valid  (m_in_valid),
    .b_out_mode  (b_out_mode),
    .b_out_x     (b_out_x),
    .b_out_y     (b_out_y),
    .b_out_notify(b_out_notify),
    .b_out_sync  (b_out_sync),
    .xfer_cnt    (xfer_cnt),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] notify;
    logic          mode;
    logic [DW-1:0] x;
    logic          y;
    logic [CW-1:0] cnt;
  } offer_t;

  offer_t exp_q[$];
  int     n_vec = 0;
  int     n_mis = 0;
  bit     prev_nz = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [NC-1:0] n, input logic md, input logic [DW-1:0] xv,
                      input logic yv, input logic [CW-1:0] c);
    offer_t o;
    o.notify = n;
    o.mode   = md;
    o.x      = xv;
    o.y      = yv;
    o.cnt    = c;
    exp_q.push_back(o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a new offer is a non-zero notify following an all-zero sample.
  always @(negedge clk) begin
    offer_t e;
    if (!rst) begin
      prev_nz = 1'b0;
    end else begin
      if (b_out_notify != '0 && !prev_nz) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_offer: got notify 0x%0h expected none", b_out_notify);
        end else begin
          e = exp_q.pop_front();
          chk("offer_notify", 64'(b_out_notify), 64'(e.notify));
          chk("offer_mode", 64'(b_out_mode), 64'(e.mode));
          chk("offer_x", 64'(b_out_x), 64'(e.x));
          chk("offer_y", 64'(b_out_y), 64'(e.y));
          chk("offer_cnt", 64'(xfer_cnt), 64'(e.cnt));
        end
      end
      prev_nz = (b_out_notify != '0);
    end
  end

  initial begin
    rst        = 1'b0;
    b_out_sync = '0;
    m_in_valid = 1'b0;
    m_in_mode  = 1'b0;
    m_in_x     = '0;
    m_in_y     = 1'b0;
    push(2'b01, 1'b0, 8'h00, 1'b0, 16'd0);
    repeat (2) tick();
    chk("reset_notify", 64'(b_out_notify), 64'h1);
    chk("reset_cnt", 64'(xfer_cnt), 64'h0);
    chk("reset_timeout", 64'(timeout_o), 64'h0);
    rst = 1'b1;

    // Offer held with no sync
    repeat (3) tick();
    chk("hold_notify", 64'(b_out_notify), 64'h1);
    chk("hold_x", 64'(b_out_x), 64'h0);
    chk("hold_cnt", 64'(xfer_cnt), 64'h0);

    // Transfer on ch0, then WRITE 0x55 y=1
    b_out_sync = 2'b01;
    tick();
    b_out_sync = '0;
    chk("b_notify_clear", 64'(b_out_notify), 64'h0);
    chk("cnt_after_first", 64'(xfer_cnt), 64'h1);
    m_in_mode = 1'b1; m_in_x = 8'h55; m_in_y = 1'b1; m_in_valid = 1'b1;
    push(2'b10, 1'b1, 8'h55, 1'b1, 16'd1);
    tick();
    m_in_valid = 1'b0;
    chk("ch1_notify", 64'(b_out_notify), 64'h2);

    // Sync on the wrong channel is ignored
    b_out_sync = 2'b01;
    tick();
    chk("wrong_sync_notify", 64'(b_out_notify), 64'h2);
    chk("wrong_sync_cnt", 64'(xfer_cnt), 64'h1);
    b_out_sync = 2'b10;
    tick();
    b_out_sync = '0;
    chk("cnt_after_ch1", 64'(xfer_cnt), 64'h2);

    // READ: x = 0x55 + 1, m_in_x ignored
    m_in_mode = 1'b0; m_in_x = 8'h99; m_in_y = 1'b0; m_in_valid = 1'b1;
    push(2'b01, 1'b0, 8'h56, 1'b0, 16'd2);
    tick();
    m_in_valid = 1'b0;

    b_out_sync = 2'b01;
    tick();
    b_out_sync = '0;
    m_in_mode = 1'b1; m_in_x = 8'hFF; m_in_y = 1'b0; m_in_valid = 1'b1;
    push(2'b10, 1'b1, 8'hFF, 1'b0, 16'd3);
    tick();
    m_in_valid = 1'b0;

    // READ from 0xFF wraps to 0x00
    b_out_sync = 2'b10;
    tick();
    b_out_sync = '0;
    m_in_mode = 1'b0; m_in_y = 1'b1; m_in_valid = 1'b1;
    push(2'b01, 1'b0, 8'h00, 1'b1, 16'd4);
    tick();
    m_in_valid = 1'b0;

    // Stall in SECTION_B with sync asserted on both channels
    b_out_sync = 2'b01;
    tick();
    b_out_sync = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_notify", 64'(b_out_notify), 64'h0);
      chk("stall_cnt", 64'(xfer_cnt), 64'd5);
    end
    b_out_sync = '0;
    m_in_mode = 1'b0; m_in_y = 1'b0; m_in_valid = 1'b1;
    push(2'b10, 1'b0, 8'h01, 1'b0, 16'd5);
    tick();
    m_in_valid = 1'b0;
    chk("resume_notify", 64'(b_out_notify), 64'h2);

    // Reset mid-offer on ch1
    tick();
    rst = 1'b0;
    exp_q.delete();
    push(2'b01, 1'b0, 8'h00, 1'b0, 16'd0);
    #1;
    chk("midrst_notify", 64'(b_out_notify), 64'h1);
    chk("midrst_x", 64'(b_out_x), 64'h0);
    chk("midrst_mode", 64'(b_out_mode), 64'h0);
    chk("midrst_y", 64'(b_out_y), 64'h0);
    chk("midrst_cnt", 64'(xfer_cnt), 64'h0);
    tick();
    rst = 1'b1;

    // Back-to-back transfers: sync held, valid held, READ
    b_out_sync = 2'b11; m_in_valid = 1'b1; m_in_mode = 1'b0; m_in_y = 1'b0;
    push(2'b10, 1'b0, 8'h01, 1'b0, 16'd1);
    push(2'b01, 1'b0, 8'h02, 1'b0, 16'd2);
    repeat (4) tick();
    b_out_sync = '0;
    m_in_valid = 1'b0;
    chk("b2b_cnt", 64'(xfer_cnt), 64'd2);
    chk("b2b_notify", 64'(b_out_notify), 64'h1);

`ifdef CSS_TIMEOUT_EN
    repeat (3) tick();
    chk("to_wait_notify", 64'(b_out_notify), 64'h1);
    chk("to_wait_pulse", 64'(timeout_o), 64'h0);
    tick();
    chk("to_pulse", 64'(timeout_o), 64'h1);
    chk("to_notify", 64'(b_out_notify), 64'h0);
    chk("to_cnt", 64'(xfer_cnt), 64'd2);
    tick();
    chk("to_pulse_end", 64'(timeout_o), 64'h0);
    m_in_mode = 1'b0; m_in_valid = 1'b1;
    push(2'b10, 1'b0, 8'h03, 1'b0, 16'd2);
    tick();
    m_in_valid = 1'b0;
    chk("to_next_ch", 64'(b_out_notify), 64'h2);
`else
    repeat (20) tick();
    chk("nto_pulse", 64'(timeout_o), 64'h0);
    chk("nto_notify", 64'(b_out_notify), 64'h1);
    chk("nto_cnt", 64'(xfer_cnt), 64'd2);
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
